// File: rtl/spi_gpio_master.sv
// spi_gpio_master: SPI mode-0 initiator writing one DATA_WIDTH-bit word per
// frame to the AFE CPLD's SPI-loaded GPIO register, using a START/BUSY/DONE
// handshake.
// Optional feature: define SPI_READBACK_EN to build the MISO capture path.
// Without it RX_DATA is tied to zero and MISO is unused.
// DATA_WIDTH must be at least 2. CLK_DIV and CS_GUARD must be at least 1.
module spi_gpio_master #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CS_GUARD   = 2
) (
  input  logic                  CLK,
  input  logic                  RST_B,
  input  logic                  START,
  input  logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  CS_B,
  output logic                  SCLK,
  output logic                  MOSI,
  input  logic                  MISO
);

  localparam int unsigned CNT_MAX = (CLK_DIV > CS_GUARD) ? CLK_DIV : CS_GUARD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(CS_GUARD - 1);
  localparam logic [BIT_W-1:0] BIT_FIRST  = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d;
  logic                  cs_b_q, cs_b_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Qualifiers shared by the frame FSM and the optional readback path.
  logic sclk_rise;
  logic frame_end;
  assign sclk_rise = (state_q == ST_SHIFT) && !sclk_q && (cnt_q == DIV_LAST);
  assign frame_end = (state_q == ST_HOLD) && (cnt_q == GUARD_LAST);

  // Frame state and registered SPI pins; reset forces the bus idle at once.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      cs_b_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      cs_b_q  <= cs_b_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-pin values; pins are computed one cycle ahead so
  // every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    cs_b_d  = cs_b_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          sh_d    = TX_DATA;
          cs_b_d  = 1'b0;
          busy_d  = 1'b1;
          mosi_d  = TX_DATA[DATA_WIDTH-1];
        end
      end

      ST_SETUP: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = BIT_FIRST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == '0) begin
              state_d = ST_HOLD;
            end else begin
              // Next bit goes out on the same edge SCLK falls.
              bit_d  = bit_q - BIT_W'(1);
              sh_d   = sh_q << 1;
              mosi_d = sh_d[DATA_WIDTH-1];
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HOLD: begin
        if (frame_end) begin
          state_d = ST_GAP;
          cnt_d   = '0;
          cs_b_d  = 1'b1;
          mosi_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        cs_b_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign CS_B = cs_b_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

`ifdef SPI_READBACK_EN
  logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;

  // MISO capture register and the word published at DONE.
  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      rx_sh_q   <= '0;
      rx_data_q <= '0;
    end else begin
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
    end
  end

  // Sample MISO on the edge that raises SCLK; publish with the DONE pulse.
  always_comb begin
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    if (sclk_rise) begin
      rx_sh_d = DATA_WIDTH'({rx_sh_q, MISO});
    end
    if (frame_end) begin
      rx_data_d = rx_sh_q;
    end
  end

  assign RX_DATA = rx_data_q;
`else
  logic unused_miso;
  logic unused_sclk_rise;
  assign unused_miso      = MISO;
  assign unused_sclk_rise = sclk_rise;
  assign RX_DATA          = '0;
`endif

endmodule
